md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit with architectural HI/LO registers. It sits in the E stage of the five-stage MIPS pipeline and produces the `E_hiloData` value that the D- and E-stage forwarding selectors consume. It executes mult/multu/div/divu over a fixed multi-cycle latency and handles mthi/mtlo/mfhi/mflo. It exports a busy indication so the hazard unit can stall dependent md-class instructions in D.

## Interface
- `MULT_CYCLES`, 5: busy cycles after a mult/multu start (≥1).
- `DIV_CYCLES`, 10: busy cycles after a div/divu start (≥1).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `E_mdOp`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none.
- `E_rsData`  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- `E_rtData`  in  32  forwarded rt operand (divisor / multiplier).
- `E_start`  out  1  combinational; 1 when `E_mdOp` ∈ {1..4} and `E_busy`=0.
- `E_busy`  out  1  registered; 1 while an operation is in flight.
- `E_hiloData`  out  32  combinational; HI when op=7, LO when op=8, else 0.

## Operation
- State: `HI`, `LO`, `hiPend`, `loPend`, down-counter `cnt` (width covers max(MULT_CYCLES, DIV_CYCLES)), and `E_busy`.
- Reset (async, `reset`=0) forces HI=LO=hiPend=loPend=0, cnt=0, E_busy=0. A reset during an in-flight op aborts it, and no result is committed.
- IDLE (E_busy=0):
  - op 1–4 (`E_start`=1): compute the result from the operands present this cycle and latch it into hiPend/loPend. Load cnt with MULT_CYCLES or DIV_CYCLES and set E_busy.
  - op 5: HI←E_rsData at the edge. op 6: LO←E_rsData at the edge.
- BUSY (E_busy=1): cnt decrements each edge. On the edge where cnt goes 1→0: HI←hiPend, LO←loPend, E_busy←0.
- Any op presented while E_busy=1 is ignored. No start, no mthi/mtlo write, and E_hiloData still reflects the committed HI/LO.
  - The hazard unit stalls md-class D instructions when `E_start|E_busy`, so this path is defensive only.
- Arithmetic:
  - mult: signed 32×32→64, HI=product[63:32], LO=product[31:0].
  - multu: the same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): the op still takes DIV_CYCLES busy cycles, and hiPend/loPend are loaded with the current HI/LO, so HI/LO are unchanged at commit.
- mfhi/mflo are pure reads of committed HI/LO. An mthi/mtlo in the same cycle is not bypassed; the new value appears the following cycle.

## Timing
- An op in E during cycle k with E_start=1 drives E_busy=1 in cycles k+1 … k+N (N = MULT_CYCLES or DIV_CYCLES).
- The new HI/LO are visible (E_hiloData) from cycle k+N+1.
- E_busy=0 in cycle k+N+1, so a back-to-back start can occur in cycle k+N+1.
- mthi/mtlo in cycle k: the value is readable by mfhi/mflo in cycle k+1.
- E_start and E_hiloData are combinational from E_mdOp and registered state. They have no dependence on E_rsData/E_rtData except through the latched result.
- All outputs have zero latency after reset deassertion: E_busy=0, E_hiloData=0 for op 7/8.

## Test plan
- mult 0xFFFFFFFE × 3 (signed) → E_busy high exactly 5 cycles; then mfhi=0xFFFFFFFF and mflo=0xFFFFFFFA.
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div −7 / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000 / −1 → LO=0x80000000, HI=0.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 next cycle, then mfhi and mflo → 0x12345678 and 0x9ABCDEF0. divu x/0 afterwards leaves both unchanged.
- Start mult, pulse reset low in the 3rd busy cycle → E_busy=0 immediately, HI=LO=0, no later commit. Also: mthi presented mid-busy → ignored, HI unchanged.

Source files
------------

// File: rtl/md_if.sv
// md_if: E-stage multiply/divide request bundle with busy/start status and HI/LO read-back.
interface md_if;
  logic [3:0] E_mdOp;
  logic [31:0] E_rsData;
  logic [31:0] E_rtData;
  logic E_start;
  logic E_busy;
  logic [31:0] E_hiloData;
  modport master(output E_mdOp, E_rsData, E_rtData, input E_start, E_busy, E_hiloData);
  modport slave(input E_mdOp, E_rsData, E_rtData, output E_start, E_busy, E_hiloData);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/multu/div/divu with architectural HI/LO, mthi/mtlo/mfhi/mflo.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave md
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} mdState;
  mdState state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [31:0] hi, lo, hiPend, loPend, hiNext, loNext, hiPendNext, loPendNext;
  logic [31:0] rs, rt, divisor, rsMag, rtMag, qMag, rMag, quo, rem;
  logic [63:0] prodS, prodU, result;
  logic divZero;
  assign rs = md.E_rsData;
  assign rt = md.E_rtData;
  assign md.E_busy = state == BUSY;
  assign md.E_start = md.E_mdOp >= 4'd1 && md.E_mdOp <= 4'd4 && state == IDLE;
  assign md.E_hiloData = md.E_mdOp == 4'd7 ? hi : md.E_mdOp == 4'd8 ? lo : 32'd0;
  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  always_comb begin
    prodS = 64'($signed(rs)) * 64'($signed(rt));
    prodU = {32'd0, rs} * {32'd0, rt};
    divZero = rt == 32'd0;
    divisor = divZero ? 32'd1 : rt;
    rsMag = rs[31] ? -rs : rs;
    rtMag = divisor[31] ? -divisor : divisor;
    qMag = rsMag / rtMag;
    rMag = rsMag % rtMag;
    quo = (rs[31] ^ divisor[31]) ? -qMag : qMag;
    rem = rs[31] ? -rMag : rMag;
    result = md.E_mdOp == 4'd1 ? prodS :
             md.E_mdOp == 4'd2 ? prodU :
             divZero ? {hi, lo} :
             md.E_mdOp == 4'd3 ? {rem, quo} : {rs % divisor, rs / divisor};
  end
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    hiNext = hi;
    loNext = lo;
    hiPendNext = hiPend;
    loPendNext = loPend;
    if (state == IDLE) begin
      if (md.E_start) begin
        {hiPendNext, loPendNext} = result;
        cntNext = md.E_mdOp <= 4'd2 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        stateNext = BUSY;
      end else if (md.E_mdOp == 4'd5) hiNext = rs;
      else if (md.E_mdOp == 4'd6) loNext = rs;
    end else begin
      cntNext = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        hiNext = hiPend;
        loNext = loPend;
        stateNext = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      hiPend <= '0;
      loPend <= '0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      hi <= hiNext;
      lo <= loNext;
      hiPend <= hiPendNext;
      loPend <= loPendNext;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plus randomized checks of md_unit against a cycle-level reference model.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  md_if mif();
  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut(.clk(clk), .reset(reset), .md(mif));
  int nVec = 0, nMis = 0, cyc = 0, busyEnd = 0;
  logic [31:0] mHi = 0, mLo = 0, pHi = 0, pLo = 0;
  bit pend = 0;
  logic obsStart, obsBusy;
  logic [31:0] obsHilo;
  function automatic logic [63:0] mdRef(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] h, logic [31:0] l);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 4'd1) return 64'(sa * sb);
    if (op == 4'd2) return 64'(ua * ub);
    if (b == 32'd0) return {h, l};
    if (op == 4'd3) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic eBusy, eStart;
    logic [31:0] eHilo;
    mif.E_mdOp = op;
    mif.E_rsData = a;
    mif.E_rtData = b;
    if (pend && cyc == busyEnd + 1) begin
      mHi = pHi;
      mLo = pLo;
      pend = 0;
    end
    eBusy = pend;
    eStart = op >= 4'd1 && op <= 4'd4 && !eBusy;
    eHilo = op == 4'd7 ? mHi : op == 4'd8 ? mLo : 32'd0;
    @(negedge clk);
    obsStart = mif.E_start;
    obsBusy = mif.E_busy;
    obsHilo = mif.E_hiloData;
    check("start", 64'(obsStart), 64'(eStart));
    check("busy", 64'(obsBusy), 64'(eBusy));
    check("hiloData", 64'(obsHilo), 64'(eHilo));
    if (eStart) begin
      {pHi, pLo} = mdRef(op, a, b, mHi, mLo);
      pend = 1;
      busyEnd = cyc + (op <= 4'd2 ? MC : DC);
    end else if (!eBusy && op == 4'd5) mHi = a;
    else if (!eBusy && op == 4'd6) mLo = a;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(logic [3:0] op, logic [31:0] exp, string name);
    cycle(op, 32'd0, 32'd0);
    check(name, 64'(obsHilo), 64'(exp));
  endtask
  task automatic runOp(logic [3:0] op, logic [31:0] a, logic [31:0] b, int n);
    int c = 0;
    cycle(op, a, b);
    check("opStart", 64'(obsStart), 64'd1);
    repeat (n + 1) begin
      cycle(4'd0, 32'd0, 32'd0);
      c += int'(obsBusy);
    end
    check("busyLen", 64'(c), 64'(n));
  endtask
  task automatic pulseReset();
    mif.E_mdOp = 4'd7;
    reset = 1'b0;
    #1;
    check("rstBusy", 64'(mif.E_busy), 64'd0);
    check("rstHilo", 64'(mif.E_hiloData), 64'd0);
    pend = 0;
    mHi = 0;
    mLo = 0;
    reset = 1'b1;
    #1;
  endtask
  function automatic logic [31:0] pick();
    int s = $urandom_range(0, 7);
    return s == 0 ? 32'd0 : s == 1 ? 32'hFFFFFFFF : s == 2 ? 32'h80000000 : s == 3 ? 32'd1 : 32'($urandom);
  endfunction
  initial begin
    reset = 1'b0;
    mif.E_mdOp = 4'd7;
    mif.E_rsData = 0;
    mif.E_rtData = 0;
    #2;
    check("inResetBusy", 64'(mif.E_busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd(4'd7, 32'd0, "resetHi");
    rd(4'd8, 32'd0, "resetLo");
    runOp(4'd1, 32'hFFFFFFFE, 32'd3, MC);
    rd(4'd7, 32'hFFFFFFFF, "multHi");
    rd(4'd8, 32'hFFFFFFFA, "multLo");
    runOp(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MC);
    rd(4'd7, 32'hFFFFFFFE, "multuHi");
    rd(4'd8, 32'h00000001, "multuLo");
    runOp(4'd3, 32'hFFFFFFF9, 32'd2, DC);
    rd(4'd8, 32'hFFFFFFFD, "divLo");
    rd(4'd7, 32'hFFFFFFFF, "divHi");
    runOp(4'd3, 32'h80000000, 32'hFFFFFFFF, DC);
    rd(4'd8, 32'h80000000, "divOvfLo");
    rd(4'd7, 32'h00000000, "divOvfHi");
    cycle(4'd5, 32'h12345678, 32'd0);
    cycle(4'd6, 32'h9ABCDEF0, 32'd0);
    rd(4'd7, 32'h12345678, "mthiRead");
    rd(4'd8, 32'h9ABCDEF0, "mtloRead");
    runOp(4'd4, 32'h00001234, 32'd0, DC);
    rd(4'd7, 32'h12345678, "divZeroHi");
    rd(4'd8, 32'h9ABCDEF0, "divZeroLo");
    cycle(4'd1, 32'd5, 32'd7);
    cycle(4'd0, 32'd0, 32'd0);
    cycle(4'd0, 32'd0, 32'd0);
    pulseReset();
    repeat (8) cycle(4'd0, 32'd0, 32'd0);
    rd(4'd7, 32'd0, "abortHi");
    rd(4'd8, 32'd0, "abortLo");
    cycle(4'd5, 32'h11111111, 32'd0);
    cycle(4'd1, 32'd2, 32'd3);
    cycle(4'd5, 32'hDEADBEEF, 32'd0);
    rd(4'd7, 32'h11111111, "mthiIgnored");
    repeat (MC) cycle(4'd0, 32'd0, 32'd0);
    rd(4'd8, 32'd6, "multAfterIgnore");
    for (int i = 0; i < 500; i++) begin
      logic [3:0] op;
      op = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      if ($urandom_range(0, 99) == 0) pulseReset();
      cycle(op, pick(), pick());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
